// File: rtl/envia_pkg.sv
// ============================================================================
// Module      : envia_pkg
// Description : Shared types and default parameters for the code-entry
//               transmitter (envia_codigo) and its timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package envia_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        WAIT   = 3'd3,
        CLEAR  = 3'd4
    } state_t;

    typedef logic [1:0] sym_t;

    localparam int N_SYM_DEFAULT   = 2;
    localparam int HOLD_DEFAULT    = 2;
    localparam int TIMEOUT_DEFAULT = 8;
    localparam int MAX_TRY_DEFAULT = 3;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/envia_codigo_temporizador.sv
// ============================================================================
// Module      : temporizador
// Description : Loadable down-counter with zero flag; saturates at zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module temporizador #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/envia_codigo.sv
// ============================================================================
// Module      : envia_codigo
// Description : Sends a stored symbol sequence to the combination lock and
//               retries after an error (retry enabled by ENVIA_RETRY_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module envia_codigo
    import envia_pkg::*;
#(
    parameter int N_SYM   = N_SYM_DEFAULT,
    parameter int HOLD    = HOLD_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int MAX_TRY = MAX_TRY_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [2*N_SYM-1:0]         code,
    input  logic                       s1,
    input  logic                       s2,
    output logic                       e0,
    output logic                       e1,
    output logic                       e2,
    output logic                       busy,
    output logic                       done,
    output logic                       ok,
    output logic                       tmo,
    output logic [$clog2(MAX_TRY+1)-1:0] tries
);

    localparam int TRY_W = $clog2(MAX_TRY + 1);
    localparam int IDX_W = (N_SYM > 1) ? $clog2(N_SYM) : 1;
    localparam int TMR_W = $clog2(max2(HOLD, TIMEOUT) + 1);
`ifdef ENVIA_RETRY_EN
    localparam int TRY_LIMIT = MAX_TRY;
`else
    localparam int TRY_LIMIT = 1;
`endif

    state_t                 state_q, state_d;
    sym_t [N_SYM-1:0]       code_q, code_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [TRY_W-1:0]       tries_q, tries_d;
    sym_t                   sym_q, sym_d;
    logic                   e2_q, e2_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   ok_q, ok_d;
    logic                   tmo_q, tmo_d;

    logic                   tmr_load;
    logic [TMR_W-1:0]       tmr_val;
    logic                   tmr_dec;
    logic                   tmr_zero;

    temporizador #(
        .WIDTH (TMR_W)
    ) u_tmr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        idx_d    = idx_q;
        tries_d  = tries_q;
        ok_d     = ok_q;
        tmo_d    = tmo_q;
        done_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;

        case (state_q)
            IDLE: begin
                // The cycle that reports done never accepts a new request.
                if (start && !done_q) begin
                    state_d  = SETUP;
                    code_d   = code;
                    idx_d    = '0;
                    tries_d  = TRY_W'(1);
                    ok_d     = 1'b0;
                    tmo_d    = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(HOLD - 1);
                end
            end
            SETUP: begin
                if (tmr_zero) begin
                    state_d = STROBE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            STROBE: begin
                tmr_load = 1'b1;
                if (idx_q == IDX_W'(N_SYM - 1)) begin
                    state_d = WAIT;
                    tmr_val = TMR_W'(TIMEOUT - 1);
                end else begin
                    state_d = SETUP;
                    idx_d   = idx_q + IDX_W'(1);
                    tmr_val = TMR_W'(HOLD - 1);
                end
            end
            WAIT: begin
                if (s1) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    ok_d    = 1'b1;
                end else if (s2) begin
                    state_d = CLEAR;
                end else if (tmr_zero) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    tmo_d   = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            CLEAR: begin
                if (tries_q < TRY_W'(TRY_LIMIT)) begin
                    state_d  = SETUP;
                    tries_d  = tries_q + TRY_W'(1);
                    idx_d    = '0;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(HOLD - 1);
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        sym_d  = sym_q;
        e2_d   = (state_d == STROBE) || (state_d == CLEAR);
        busy_d = (state_d != IDLE);
        if ((state_d == SETUP) && (state_q != SETUP)) begin
            sym_d = code_d[idx_d];
        end else if (state_d == CLEAR) begin
            sym_d = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            code_q  <= '0;
            idx_q   <= '0;
            tries_q <= '0;
            sym_q   <= 2'b00;
            e2_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            idx_q   <= idx_d;
            tries_q <= tries_d;
            sym_q   <= sym_d;
            e2_q    <= e2_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            tmo_q   <= tmo_d;
        end
    end

    assign e0    = sym_q[0];
    assign e1    = sym_q[1];
    assign e2    = e2_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign ok    = ok_q;
    assign tmo   = tmo_q;
    assign tries = tries_q;

endmodule

`default_nettype wire
